nn_udiv_33ns_18ns_16_seq: RTL and testbench
===========================================

NN_UDIV_33NS_18NS_16_SEQ -- requirements
Module: NN_udiv_33ns_18ns_16_seq

Interface
REQ-001 The block SHALL have parameter ID, default 1, meaning instance identifier with no functional effect.
REQ-002 The block SHALL have parameter din0_WIDTH, default 33, meaning dividend width.
REQ-003 The block SHALL have parameter din1_WIDTH, default 18, meaning divisor width.
REQ-004 The block SHALL have parameter dout_WIDTH, default 16, meaning quotient output width.
REQ-005 The block SHALL have port ap_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port ap_rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port ce, input, 1 bit: clock enable; 0 freezes all state.
REQ-008 The block SHALL have port start, input, 1 bit: request to begin a division.
REQ-009 The block SHALL have port din0, input, din0_WIDTH bits: unsigned dividend.
REQ-010 The block SHALL have port din1, input, din1_WIDTH bits: unsigned divisor.
REQ-011 The block SHALL have port busy, output, 1 bit: high while dividing.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle result-valid pulse.
REQ-013 The block SHALL have port dout, output, dout_WIDTH bits: saturated quotient.
REQ-014 The block SHALL have port rem_out, output, din1_WIDTH bits: remainder.
REQ-015 The block SHALL have port ovf, output, 1 bit: quotient exceeded dout_WIDTH and was saturated.
REQ-016 The block SHALL have port div_by_zero, output, 1 bit: divisor was zero.

Function
REQ-017 The block SHALL implement FSM states IDLE, CALC and DONE, with all outputs driven from registers.
REQ-018 In IDLE or DONE, when ce=1 and start=1, the block SHALL latch din0 and din1, clear the iteration counter, and enter CALC on that edge (edge 0).
REQ-019 In CALC, the block SHALL perform one radix-2 restoring iteration per ce=1 edge, producing a full din0_WIDTH-bit quotient after exactly din0_WIDTH iterations.
REQ-020 On the din0_WIDTH-th CALC iteration edge, the block SHALL enter DONE and update dout, rem_out, ovf and div_by_zero.
REQ-021 With ce held at 1, done SHALL be high exactly during the cycle following edge 33 (default widths) and for one ce=1 cycle only; DONE then returns to IDLE unless start=1 re-launches.
REQ-022 busy SHALL be 1 exactly while the state is CALC.
REQ-023 The block SHALL ignore start while in CALC; latched operands SHALL be unaffected by input changes after edge 0.
REQ-024 When ce=0, the state, counter, datapath and all outputs, including a pending done, SHALL hold.
REQ-025 If the full quotient is below 2^dout_WIDTH, the block SHALL set dout to the quotient and ovf to 0.
REQ-026 If the full quotient is at or above 2^dout_WIDTH, the block SHALL set dout to all ones and ovf to 1.
REQ-027 rem_out SHALL equal dividend mod divisor, which always fits din1_WIDTH bits.
REQ-028 For a divisor of 0, the block SHALL still take full latency and SHALL produce dout=all ones, rem_out=din0[din1_WIDTH-1:0], div_by_zero=1 and ovf=0.
REQ-029 dout, rem_out, ovf and div_by_zero SHALL hold their values from the DONE edge until the next DONE edge.

Reset
REQ-030 While ap_rst=1, regardless of clock or ce, the state SHALL be IDLE and the outputs SHALL be busy=0, done=0, dout=0, rem_out=0, ovf=0, div_by_zero=0.
REQ-031 A reset asserted mid-CALC SHALL abort the operation; no done SHALL follow reset release without a new start.

Verification
REQ-032 din0=100000, din1=7, start for one cycle, ce=1 -> done exactly 33 cycles after the start edge, dout=14285, rem_out=5, ovf=0, div_by_zero=0.
REQ-033 din0=0x1_FFFF_FFFF, din1=0x3FFFF -> dout=0x8000, rem_out=32767, ovf=0.
REQ-034 din0=0x1_0000_0000, din1=1 -> dout=0xFFFF, rem_out=0, ovf=1; then din0=12345, din1=0 -> dout=0xFFFF, rem_out=12345, div_by_zero=1, ovf=0.
REQ-035 Start 100000/7, deassert ce for 5 cycles mid-CALC, and pulse start with other operands while busy -> done arrives 38 cycles after the start edge with results 14285 and 5; the second start is ignored.
REQ-036 Assert ap_rst asynchronously 10 cycles into CALC -> outputs go to zero immediately; no done pulse follows until a new start completes normally.
REQ-037 Start asserted in the DONE cycle -> new operation accepted with back-to-back throughput of one result per 34 cycles.

Source files
------------

// File: rtl/nn_udiv_33ns_18ns_16_seq.sv
// Sequential radix-2 restoring unsigned divider with a saturated quotient.
// A division is launched by start (with ce=1) from IDLE or DONE. It runs one
// quotient bit per enabled clock for din0_WIDTH clocks, then reports for a
// single enabled cycle in DONE. The ce input freezes every register.
// Ports:
//   ap_clk, ap_rst   - clock, asynchronous active-high reset
//   ce               - clock enable (0 holds all state and outputs)
//   start            - launch request (ignored while busy)
//   din0, din1       - unsigned dividend / divisor
//   busy             - high while the state is CALC
//   done             - one-cycle result-valid pulse
//   dout             - quotient, saturated to all ones when it overflows
//   rem_out          - remainder
//   ovf              - quotient did not fit dout_WIDTH bits
//   div_by_zero      - divisor was zero
module nn_udiv_33ns_18ns_16_seq #(
    parameter int unsigned ID         = 1,
    parameter int unsigned din0_WIDTH = 33,
    parameter int unsigned din1_WIDTH = 18,
    parameter int unsigned dout_WIDTH = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  busy,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem_out,
    output logic                  ovf,
    output logic                  div_by_zero
);

    localparam int unsigned W0 = din0_WIDTH;
    localparam int unsigned W1 = din1_WIDTH;
    localparam int unsigned DW = dout_WIDTH;
    localparam int unsigned CW = $clog2(W0 + 1);

    // ID carries no behaviour; the empty block only gives it a reference.
    if (ID == 0) begin : g_id_zero
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // Dividend shifts out at the MSB while quotient bits shift in at the LSB.
    logic [W0-1:0]   dvd_q, dvd_d;
    logic [W1-1:0]   dsr_q, dsr_d;
    logic [W1-1:0]   rem_q, rem_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DW-1:0]   dout_q, dout_d;
    logic [W1-1:0]   rem_out_q, rem_out_d;
    logic            ovf_q, ovf_d;
    logic            dbz_q, dbz_d;

    // One restoring step: the partial remainder is always below the divisor,
    // so after the shift it needs one extra bit, and after the conditional
    // subtract it fits back into W1 bits.
    logic [W1:0]     rem_shift;
    logic [W1-1:0]   rem_sub;
    logic            q_bit;
    logic [W0-1:0]   q_full;
    logic            q_ovf;
    logic            dsr_zero;

    always_comb begin
        rem_shift = {rem_q, dvd_q[W0-1]};
        q_bit     = (rem_shift >= {1'b0, dsr_q});
        rem_sub   = rem_shift[W1-1:0] - dsr_q;
        q_full    = {dvd_q[W0-2:0], q_bit};
        q_ovf     = |q_full[W0-1:DW];
        dsr_zero  = (dsr_q == '0);
    end

    // Next-state, datapath and output registers; nothing moves without ce.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        busy_d    = busy_q;
        done_d    = done_q;
        dout_d    = dout_q;
        rem_out_d = rem_out_q;
        ovf_d     = ovf_q;
        dbz_d     = dbz_q;

        if (ce) begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (start) begin
                        dvd_d   = din0;
                        dsr_d   = din1;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    dvd_d = q_full;
                    rem_d = q_bit ? rem_sub : rem_shift[W1-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(W0 - 1)) begin
                        state_d   = DONE;
                        rem_out_d = q_bit ? rem_sub : rem_shift[W1-1:0];
                        // A zero divisor yields an all-ones quotient; it is
                        // flagged as div_by_zero rather than overflow.
                        dbz_d     = dsr_zero;
                        ovf_d     = q_ovf && !dsr_zero;
                        dout_d    = (q_ovf || dsr_zero) ? '1 : q_full[DW-1:0];
                    end
                end
                default: state_d = IDLE;
            endcase
            busy_d = (state_d == CALC);
            done_d = (state_d == DONE);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dout_q    <= '0;
            rem_out_q <= '0;
            ovf_q     <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dout_q    <= dout_d;
            rem_out_q <= rem_out_d;
            ovf_q     <= ovf_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign dout        = dout_q;
    assign rem_out     = rem_out_q;
    assign ovf         = ovf_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_nn_udiv_33ns_18ns_16_seq.sv
// Scoreboard bench for nn_udiv_33ns_18ns_16_seq: expected results and done
// cycles are queued at launch and compared when done is seen.
module tb_nn_udiv_33ns_18ns_16_seq;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ce;
    logic        start;
    logic [32:0] din0;
    logic [17:0] din1;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [17:0] rem_out;
    logic        ovf;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] dout;
        logic [17:0] rem;
        logic        ovf;
        logic        dbz;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int          checks = 0;
    int          errors = 0;

    nn_udiv_33ns_18ns_16_seq #(
        .ID(1), .din0_WIDTH(33), .din1_WIDTH(18), .dout_WIDTH(16)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start),
        .din0(din0), .din1(din1), .busy(busy), .done(done),
        .dout(dout), .rem_out(rem_out), .ovf(ovf), .div_by_zero(div_by_zero)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [32:0] a, input logic [17:0] b);
        exp_t        e;
        logic [32:0] q;
        e.cyc = 0;
        if (b == 18'd0) begin
            e.dout = 16'hFFFF;
            e.rem  = a[17:0];
            e.ovf  = 1'b0;
            e.dbz  = 1'b1;
        end else begin
            q      = a / {15'd0, b};
            e.rem  = 18'(a % {15'd0, b});
            e.dbz  = 1'b0;
            e.ovf  = (q > 33'h0FFFF);
            e.dout = e.ovf ? 16'hFFFF : q[15:0];
        end
        return e;
    endfunction

    // Called at a negedge; the following posedge is the launch edge.
    task automatic launch(input logic [32:0] a, input logic [17:0] b, input int unsigned extra);
        exp_t e;
        din0  = a;
        din1  = b;
        start = 1'b1;
        e     = model(a, b);
        e.cyc = cyc + 34 + extra;
        sb.push_back(e);
        @(negedge ap_clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge ap_clk);
        check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Result monitor: every done pulse must match the oldest queued launch.
    always @(negedge ap_clk) begin
        exp_t e;
        if (ap_rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            check_eq("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("dout", 64'(dout), 64'(e.dout));
                check_eq("rem_out", 64'(rem_out), 64'(e.rem));
                check_eq("ovf", 64'(ovf), 64'(e.ovf));
                check_eq("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
                check_eq("done_cycle", 64'(cyc), 64'(e.cyc));
                check_eq("busy_at_done", 64'(busy), 64'd0);
            end
        end
    end

    initial begin
        int unsigned d0;
        logic [32:0] ra;
        logic [17:0] rb;

        ap_rst = 1'b1;
        ce     = 1'b1;
        start  = 1'b0;
        din0   = '0;
        din1   = '0;
        repeat (3) @(negedge ap_clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_dout", 64'(dout), 64'd0);
        check_eq("rst_rem", 64'(rem_out), 64'd0);
        check_eq("rst_ovf", 64'(ovf), 64'd0);
        check_eq("rst_dbz", 64'(div_by_zero), 64'd0);
        ap_rst = 1'b0;
        repeat (2) @(negedge ap_clk);

        // Directed operand sets, each run to completion.
        launch(33'd100000, 18'd7, 0);            drain(60); @(negedge ap_clk);
        launch(33'h1_FFFF_FFFF, 18'h3FFFF, 0);   drain(60); @(negedge ap_clk);
        launch(33'h1_0000_0000, 18'd1, 0);       drain(60); @(negedge ap_clk);
        launch(33'd12345, 18'd0, 0);             drain(60); @(negedge ap_clk);

        // Clock-enable gap mid-CALC plus an ignored start with new operands.
        launch(33'd100000, 18'd7, 5);
        repeat (8) @(negedge ap_clk);
        ce    = 1'b0;
        din0  = 33'd999;
        din1  = 18'd3;
        start = 1'b1;
        repeat (5) @(negedge ap_clk);
        check_eq("busy_during_gap", 64'(busy), 64'd1);
        ce = 1'b1;
        @(negedge ap_clk);
        start = 1'b0;
        drain(70);
        @(negedge ap_clk);

        // Back-to-back: the second start lands in the DONE cycle.
        launch(33'd4000000, 18'd1000, 0);
        for (int i = 0; i < 60 && done !== 1'b1; i++) @(negedge ap_clk);
        check_eq("b2b_first_done", 64'(done), 64'd1);
        launch(33'h1_2345_6789, 18'd77, 0);
        drain(60);
        @(negedge ap_clk);

        // Asynchronous reset ten cycles into CALC aborts the operation.
        launch(33'd100000, 18'd7, 0);
        repeat (9) @(negedge ap_clk);
        #2 ap_rst = 1'b1;
        #1;
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_dout", 64'(dout), 64'd0);
        check_eq("abort_rem", 64'(rem_out), 64'd0);
        check_eq("abort_ovf", 64'(ovf), 64'd0);
        check_eq("abort_dbz", 64'(div_by_zero), 64'd0);
        sb.delete();
        @(negedge ap_clk);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(negedge ap_clk);
        check_eq("no_done_after_abort", 64'(done_cnt), 64'(d0));
        check_eq("idle_after_abort", 64'(busy), 64'd0);
        launch(33'd54321, 18'd123, 0);
        drain(60);
        @(negedge ap_clk);

        // A few random operands, divisors scaled to spread quotient sizes.
        for (int n = 0; n < 6; n++) begin
            ra = {1'($urandom), 32'($urandom)};
            rb = 18'($urandom) >> $urandom_range(0, 17);
            if (n == 3) rb = 18'd0;
            launch(ra, rb, 0);
            drain(60);
            @(negedge ap_clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
